// File: rtl/switch_debounce_select.sv
// -----------------------------------------------------------------------------
// switch_debounce_select
//
// Conditions the two raw Go Board push-button inputs into clean, debounced
// levels for the selective-blink LED stage. Each switch passes through a
// two-flop synchronizer and a stable-run debounce counter. A one-cycle press
// pulse marks every debounced rising edge. A single-cycle notification fires
// whenever the 2-bit selection {o_Switch_2, o_Switch_1} changes.
//
// Parameters:
//   DEBOUNCE_LIMIT : consecutive mismatch cycles required before a new level
//                    is accepted (>= 1).
//
// Ports:
//   i_Clk        : system clock, rising edge
//   i_Reset      : synchronous, active-high reset
//   i_Switch_1/2 : raw asynchronous switch inputs
//   o_Switch_1/2 : debounced switch levels
//   o_Press_1/2  : one-cycle pulse on a debounced 0->1 edge
//   o_Sel_Change : one-cycle pulse when either debounced level changes
// -----------------------------------------------------------------------------
module switch_debounce_select #(
   parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Switch_1,
   input  logic i_Switch_2,
   output logic o_Switch_1,
   output logic o_Switch_2,
   output logic o_Press_1,
   output logic o_Press_2,
   output logic o_Sel_Change
);

   localparam int unsigned CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

   logic [1:0]       w_Raw;
   logic [1:0]       w_Accept;
   logic [1:0]       r_Meta;
   logic [1:0]       r_Sync;
   logic [1:0]       r_Deb;
   logic [1:0]       r_Press;
   logic             r_Sel_Change;
   logic [CNT_W-1:0] r_Cnt [2];

   assign w_Raw = {i_Switch_2, i_Switch_1};

   // A channel accepts its new level on the cycle the mismatch run reaches the
   // limit; the press and selection-change pulses are registered from this.
   always_comb begin
      w_Accept = '0;
      for (int unsigned n = 0; n < 2; n++) begin
         w_Accept[n] = (r_Sync[n] != r_Deb[n]) && (r_Cnt[n] == CNT_MAX);
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_Meta       <= '0;
         r_Sync       <= '0;
         r_Deb        <= '0;
         r_Press      <= '0;
         r_Sel_Change <= 1'b0;
         for (int unsigned n = 0; n < 2; n++) begin
            r_Cnt[n] <= '0;
         end
      end else begin
         r_Meta <= w_Raw;
         r_Sync <= r_Meta;
         for (int unsigned n = 0; n < 2; n++) begin
            if (r_Sync[n] == r_Deb[n]) begin
               // Any short bounce back to the accepted level discards the run.
               r_Cnt[n] <= '0;
            end else if (w_Accept[n]) begin
               r_Deb[n] <= r_Sync[n];
               r_Cnt[n] <= '0;
            end else begin
               r_Cnt[n] <= r_Cnt[n] + CNT_W'(1);
            end
         end
         r_Press      <= w_Accept & r_Sync;
         // Simultaneous changes on both channels collapse into one pulse.
         r_Sel_Change <= |w_Accept;
      end
   end

   assign o_Switch_1   = r_Deb[0];
   assign o_Switch_2   = r_Deb[1];
   assign o_Press_1    = r_Press[0];
   assign o_Press_2    = r_Press[1];
   assign o_Sel_Change = r_Sel_Change;

endmodule
